// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, register index
// width and the load funct3 encodings.
package riscv_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 64;
   localparam int REG_W     = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/stage_wb_if.sv
// MEM -> WB boundary bundle: MEM-stage results entering the writeback
// stage and the register-file write port leaving it.
interface stage_wb_if #(
   parameter int XLEN  = riscv_pkg::XLEN_DEF,
   parameter int CNT_W = riscv_pkg::CNT_W_DEF
);
   import riscv_pkg::*;

   // MEM-stage side
   logic              ex_mem_valid;
   logic              ex_mem_regwrite;
   logic              ex_mem_memtoreg;
   logic [REG_W-1:0]  ex_mem_rd;
   logic [2:0]        ex_mem_funct3;
   logic [XLEN-1:0]   ex_mem_alu_result;
   logic [XLEN-1:0]   mem_read_data;
   logic              wb_stall;
   logic              wb_flush;

   // Register-file write port and status
   logic              mem_wb_regwrite;
   logic [REG_W-1:0]  mem_wb_rd;
   logic [XLEN-1:0]   wb_write_data;
   logic              wb_valid;
   logic              wb_load_misaligned;
   logic [CNT_W-1:0]  wb_instret;

   // Upstream pipeline / environment drives the MEM-side signals
   modport master (
      output ex_mem_valid, ex_mem_regwrite, ex_mem_memtoreg, ex_mem_rd,
             ex_mem_funct3, ex_mem_alu_result, mem_read_data,
             wb_stall, wb_flush,
      input  mem_wb_regwrite, mem_wb_rd, wb_write_data, wb_valid,
             wb_load_misaligned, wb_instret
   );

   // The writeback stage itself
   modport slave (
      input  ex_mem_valid, ex_mem_regwrite, ex_mem_memtoreg, ex_mem_rd,
             ex_mem_funct3, ex_mem_alu_result, mem_read_data,
             wb_stall, wb_flush,
      output mem_wb_regwrite, mem_wb_rd, wb_write_data, wb_valid,
             wb_load_misaligned, wb_instret
   );

endinterface

// File: rtl/load_extract.sv
// Combinational load-data extraction: picks the addressed byte/halfword
// out of an aligned memory word, extends it, and flags misalignment.
module load_extract
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_ofs,
   input  logic [XLEN-1:0] i_word,
   output logic [XLEN-1:0] o_data,
   output logic            o_misaligned
);

   logic [7:0]  w_bytes [4];
   logic [7:0]  w_byte_sel;
   logic [15:0] w_half_sel;

   // Little-endian byte lanes: lane k is bits [8k+7:8k]
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_bytes[gi] = i_word[8*gi +: 8];
      end
   endgenerate

   assign w_byte_sel = w_bytes[i_ofs];
   assign w_half_sel = i_ofs[1] ? i_word[31:16] : i_word[15:0];

   // Width/sign decode; unused encodings fall back to a full-word load
   always_comb begin
      o_data       = i_word;
      o_misaligned = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = {{(XLEN-8){w_byte_sel[7]}}, w_byte_sel};
         F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte_sel};
         F3_LH: begin
            o_data       = {{(XLEN-16){w_half_sel[15]}}, w_half_sel};
            o_misaligned = i_ofs[0];
         end
         F3_LHU: begin
            o_data       = {{(XLEN-16){1'b0}}, w_half_sel};
            o_misaligned = i_ofs[0];
         end
         default: begin
            o_data       = i_word;
            o_misaligned = (i_ofs != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: MEM/WB pipeline register, load/ALU result select,
// register-file write enable and retired-instruction counter.
module stage_wb
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic       clock,
   input logic       reset,
   stage_wb_if.slave wb
);

   logic [XLEN-1:0]  w_ext_data;
   logic             w_ext_misaligned;

   logic             w_valid_next;
   logic             w_regwrite_next;
   logic [REG_W-1:0] w_rd_next;
   logic [XLEN-1:0]  w_data_next;
   logic             w_misaligned_next;

   logic             r_valid;
   logic             r_regwrite;
   logic [REG_W-1:0] r_rd;
   logic [XLEN-1:0]  r_data;
   logic             r_misaligned;
   logic [CNT_W-1:0] r_instret;

   load_extract #(.XLEN(XLEN)) u_load_extract (
      .i_funct3     (wb.ex_mem_funct3),
      .i_ofs        (wb.ex_mem_alu_result[1:0]),
      .i_word       (wb.mem_read_data),
      .o_data       (w_ext_data),
      .o_misaligned (w_ext_misaligned)
   );

   // Values captured on a normal load; bubbles collapse to all zeros
   always_comb begin
      w_valid_next      = 1'b0;
      w_regwrite_next   = 1'b0;
      w_rd_next         = '0;
      w_data_next       = '0;
      w_misaligned_next = 1'b0;
      if (wb.ex_mem_valid) begin
         w_valid_next      = 1'b1;
         w_rd_next         = wb.ex_mem_rd;
         // Misalignment only matters for loads
         w_misaligned_next = wb.ex_mem_memtoreg & w_ext_misaligned;
         if (wb.ex_mem_memtoreg)
            w_data_next = w_misaligned_next ? '0 : w_ext_data;
         else
            w_data_next = wb.ex_mem_alu_result;
         // x0 is hardwired, and a faulting load must not update rd
         w_regwrite_next = wb.ex_mem_regwrite & (wb.ex_mem_rd != '0)
                           & ~w_misaligned_next;
      end
   end

   // MEM/WB register and counter: reset > flush > stall > load
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid      <= 1'b0;
         r_regwrite   <= 1'b0;
         r_rd         <= '0;
         r_data       <= '0;
         r_misaligned <= 1'b0;
         r_instret    <= '0;
      end else if (wb.wb_flush) begin
         r_valid      <= 1'b0;
         r_regwrite   <= 1'b0;
         r_rd         <= '0;
         r_data       <= '0;
         r_misaligned <= 1'b0;
      end else if (!wb.wb_stall) begin
         r_valid      <= w_valid_next;
         r_regwrite   <= w_regwrite_next;
         r_rd         <= w_rd_next;
         r_data       <= w_data_next;
         r_misaligned <= w_misaligned_next;
         // Free-running wrap at 2^CNT_W
         if (wb.ex_mem_valid)
            r_instret <= r_instret + 1'b1;
      end
   end

   assign wb.wb_valid           = r_valid;
   assign wb.mem_wb_regwrite    = r_regwrite;
   assign wb.mem_wb_rd          = r_rd;
   assign wb.wb_write_data      = r_data;
   assign wb.wb_load_misaligned = r_misaligned;
   assign wb.wb_instret         = r_instret;

endmodule

// File: tb/tb_stage_wb.sv
// Scoreboard bench for stage_wb: a driver issues one MEM-stage input set
// per cycle and queues the expected register contents; a monitor checks
// the outputs after every rising edge.
module tb_stage_wb;

   logic clock;
   logic reset;

   stage_wb_if #(.XLEN(32), .CNT_W(64)) wbi ();

   stage_wb #(.XLEN(32), .CNT_W(64)) dut (
      .clock (clock),
      .reset (reset),
      .wb    (wbi)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      logic        regwrite;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic [63:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t model;

   int checks_total  = 0;
   int checks_passed = 0;
   int txn_no        = 0;

   // Reference load semantics written from the ISA description
   function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                            input logic [31:0] addr,
                                            input logic [31:0] word,
                                            output logic mis);
      int unsigned ofs;
      int unsigned b;
      int unsigned h;
      logic [31:0] res;
      ofs = addr % 4;
      b   = (word >> (8 * ofs)) & 32'hFF;
      h   = (word >> (16 * (ofs / 2))) & 32'hFFFF;
      mis = 1'b0;
      case (f3)
         3'd0: res = (b >= 128) ? (32'hFFFFFF00 | b) : b;
         3'd4: res = b;
         3'd1: begin res = (h >= 32768) ? (32'hFFFF0000 | h) : h; mis = (ofs % 2) != 0; end
         3'd5: begin res = h; mis = (ofs % 2) != 0; end
         default: begin res = word; mis = (ofs != 0); end
      endcase
      return res;
   endfunction

   // Drive one cycle of stimulus and queue what the stage must hold afterwards
   task automatic cycle(input logic rst, input logic fl, input logic st,
                        input logic v, input logic rw, input logic m2r,
                        input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] mdata);
      logic        mis;
      logic [31:0] ld;
      @(negedge clock);
      reset                 = rst;
      wbi.wb_flush          = fl;
      wbi.wb_stall          = st;
      wbi.ex_mem_valid      = v;
      wbi.ex_mem_regwrite   = rw;
      wbi.ex_mem_memtoreg   = m2r;
      wbi.ex_mem_rd         = rd;
      wbi.ex_mem_funct3     = f3;
      wbi.ex_mem_alu_result = alu;
      wbi.mem_read_data     = mdata;
      if (rst) begin
         model = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0};
      end else if (fl) begin
         model.valid = 1'b0; model.regwrite = 1'b0; model.rd = 5'd0;
         model.data = 32'd0; model.mis = 1'b0;
      end else if (!st) begin
         if (!v) begin
            model.valid = 1'b0; model.regwrite = 1'b0; model.rd = 5'd0;
            model.data = 32'd0; model.mis = 1'b0;
         end else begin
            ld = ref_load(f3, alu, mdata, mis);
            if (!m2r) mis = 1'b0;
            model.valid    = 1'b1;
            model.rd       = rd;
            model.mis      = mis;
            model.data     = m2r ? (mis ? 32'd0 : ld) : alu;
            model.regwrite = rw && (rd != 0) && !mis;
            model.cnt      = model.cnt + 64'd1;
         end
      end
      exp_q.push_back(model);
   endtask

   // Monitor: compare registered outputs one step after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn_no++;
            checks_total++;
            if (wbi.wb_valid === e.valid && wbi.mem_wb_regwrite === e.regwrite &&
                wbi.mem_wb_rd === e.rd && wbi.wb_write_data === e.data &&
                wbi.wb_load_misaligned === e.mis && wbi.wb_instret === e.cnt) begin
               checks_passed++;
               $display("txn %0d ok: v=%0b we=%0b rd=%0d data=%08h mis=%0b cnt=%0d",
                        txn_no, e.valid, e.regwrite, e.rd, e.data, e.mis, e.cnt);
            end else begin
               $display("FAIL txn %0d outputs: got v=%0b we=%0b rd=%0d data=%08h mis=%0b cnt=%0h, want v=%0b we=%0b rd=%0d data=%08h mis=%0b cnt=%0h",
                        txn_no, wbi.wb_valid, wbi.mem_wb_regwrite, wbi.mem_wb_rd,
                        wbi.wb_write_data, wbi.wb_load_misaligned, wbi.wb_instret,
                        e.valid, e.regwrite, e.rd, e.data, e.mis, e.cnt);
            end
         end
      end
   end

   initial begin
      model = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 64'd0};
      reset = 1'b1;
      wbi.wb_flush = 1'b0; wbi.wb_stall = 1'b0;
      wbi.ex_mem_valid = 1'b0; wbi.ex_mem_regwrite = 1'b0; wbi.ex_mem_memtoreg = 1'b0;
      wbi.ex_mem_rd = 5'd0; wbi.ex_mem_funct3 = 3'd0;
      wbi.ex_mem_alu_result = 32'd0; wbi.mem_read_data = 32'd0;

      // Reset state
      cycle(1, 0, 0, 0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0);
      cycle(1, 0, 0, 1, 1, 1, 5'd3, 3'd2, 32'h0, 32'hDEADBEEF);

      // Directed loads
      cycle(0, 0, 0, 1, 1, 1, 5'd5, 3'b000, 32'h0000_1003, 32'h80112233); // LB ofs3
      cycle(0, 0, 0, 1, 1, 1, 5'd6, 3'b101, 32'h0000_2002, 32'h8001ABCD); // LHU ofs2
      cycle(0, 0, 0, 1, 1, 1, 5'd6, 3'b001, 32'h0000_2001, 32'h8001ABCD); // LH misaligned
      cycle(0, 0, 0, 1, 1, 1, 5'd9, 3'b010, 32'h0000_2002, 32'h8001ABCD); // LW misaligned
      cycle(0, 0, 0, 1, 1, 1, 5'd9, 3'b110, 32'h0000_2000, 32'hCAFEF00D); // odd funct3 as LW
      cycle(0, 0, 0, 1, 1, 0, 5'd0, 3'b000, 32'h12345678, 32'h0);          // ALU to x0
      cycle(0, 0, 0, 0, 1, 1, 5'd4, 3'b000, 32'h1, 32'hFFFFFFFF);          // bubble

      // Stall holds, then flush wins over stall
      cycle(0, 0, 0, 1, 1, 0, 5'd7, 3'b000, 32'h00000064, 32'h0);
      for (int i = 0; i < 3; i++)
         cycle(0, 0, 1, 1, 1, 0, 5'd12 + 5'(i), 3'b000, 32'hA5A5_0000 + i, 32'h0);
      cycle(0, 1, 1, 1, 1, 0, 5'd15, 3'b000, 32'h1111_1111, 32'h0);

      // Counter wrap from a preloaded all-ones value
      @(negedge clock);
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.r_instret;
      model.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(0, 0, 0, 1, 1, 0, 5'd1, 3'b000, 32'h0000_0042, 32'h0);

      // Reset alongside a valid load, then a bubble keeps the counter at 0
      cycle(0, 1, 1, 1, 1, 1, 5'd8, 3'b000, 32'h0, 32'h0);
      cycle(1, 0, 1, 1, 1, 1, 5'd8, 3'b000, 32'h1, 32'h00FF0000);
      cycle(0, 0, 0, 0, 1, 0, 5'd3, 3'b000, 32'h9, 32'h0);

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         logic [31:0] alu;
         logic [4:0]  rd;
         alu = $urandom;
         rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 6),
               ($urandom_range(0, 99) < 12),
               ($urandom_range(0, 99) < 85),
               1'($urandom),
               1'($urandom),
               rd, 3'($urandom), alu, $urandom);
      end
      cycle(0, 0, 0, 0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0);

      // Drain the scoreboard within a bounded number of cycles
      for (int w = 0; w < 10 && exp_q.size() > 0; w++)
         @(negedge clock);
      if (exp_q.size() > 0) begin
         checks_total++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Writeback stage of the 5-stage RISC-V pipeline.
- Holds the MEM/WB pipeline register and performs load-data extraction: byte/halfword select, plus sign or zero extension.
- Selects ALU result versus load data.
- Drives the register-file write port that the decode stage consumes (mem_wb_regwrite, mem_wb_rd, wb_write_data).
- Keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width in bits. Only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_valid  in  1  MEM stage holds a real instruction, not a bubble.
- ex_mem_regwrite  in  1  instruction writes rd.
- ex_mem_memtoreg  in  1  1 selects load data, 0 selects the ALU result.
- ex_mem_rd  in  5  destination register.
- ex_mem_funct3  in  3  load width/sign field.
- ex_mem_alu_result  in  XLEN  ALU result; for loads, the effective address.
- mem_read_data  in  XLEN  raw aligned word from data memory, valid in the same cycle as the ex_mem_* inputs.
- wb_stall  in  1  hold the MEM/WB register.
- wb_flush  in  1  insert a bubble.
- mem_wb_regwrite  out  1  register-file write enable.
- mem_wb_rd  out  5  register-file write address.
- wb_write_data  out  XLEN  register-file write data.
- wb_valid  out  1  MEM/WB register holds a real instruction.
- wb_load_misaligned  out  1  the retired load was misaligned; its write is suppressed.
- wb_instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (synchronous): all outputs 0 (wb_valid, mem_wb_regwrite, mem_wb_rd, wb_write_data, wb_load_misaligned, wb_instret).
- Update priority at each edge: reset > wb_flush > wb_stall > load.
- Flush: wb_valid=0, mem_wb_regwrite=0, wb_load_misaligned=0. mem_wb_rd and wb_write_data go to 0. wb_instret unchanged.
- Stall: all registers hold. wb_instret does not increment.
- Load: all ex_mem_* inputs and the extracted data are registered. Latency is exactly 1 cycle from the MEM-stage inputs to the outputs.
- Extraction, used when memtoreg=1; ofs = ex_mem_alu_result[1:0]:
  - funct3 000 (LB): sign-extend byte ofs.
  - funct3 100 (LBU): zero-extend byte ofs.
  - funct3 001 (LH): sign-extend halfword ofs[1].
  - funct3 101 (LHU): zero-extend halfword ofs[1].
  - funct3 010 (LW): full word.
  - funct3 011, 110, 111: treated as LW.
  - Byte k = mem_read_data[8k+7:8k] (little-endian).
- Misaligned, evaluated only when memtoreg=1:
  - LH/LHU with ofs[0]=1.
  - LW (or funct3 treated as LW) with ofs!=0.
  - On a misaligned load: wb_load_misaligned=1 for that instruction, wb_write_data=0, write suppressed. The instruction still retires.
- Write enable: mem_wb_regwrite = ex_mem_valid & ex_mem_regwrite & (ex_mem_rd!=0) & !misaligned, registered. A write to x0 never asserts the enable.
- Bubbles: when ex_mem_valid=0, all captured control bits are 0 and data is 0.
- Retired counter: wb_instret increments by 1 on each edge that loads with ex_mem_valid=1. It wraps modulo 2^CNT_W; there is no saturation.
- Output stability: outputs are purely registered, with no combinational path from inputs to outputs. The decode stage reads them as stable for the whole cycle.
- Reset mid-stall or mid-flush: reset wins. The instruction in flight is discarded and not counted.

Decomposition:
- Shared package, riscv_pkg: LB/LH/LW/LBU/LHU funct3 constants, the XLEN default, and the register-index width (5).
- Sub-module load_extract (combinational):
  - Inputs: funct3, ofs, word.
  - Outputs: extracted data and the misaligned flag.
  - Reused by any future store/load alignment checker.
- The top module holds the MEM/WB register, the write-enable logic and the counter.

Test Plan:
- LB, ofs=3, mem_read_data=0x80112233, rd=5, regwrite=1 -> next cycle wb_write_data=0xFFFFFF80, mem_wb_rd=5, mem_wb_regwrite=1, wb_instret=1.
- LHU, ofs=2, data=0x8001ABCD -> wb_write_data=0x00008001. LH, ofs=1 -> wb_load_misaligned=1, mem_wb_regwrite=0, wb_write_data=0, wb_instret still increments.
- ALU op, memtoreg=0, alu_result=0x12345678, rd=0, regwrite=1 -> mem_wb_regwrite=0 (x0 suppressed), wb_valid=1.
- Valid ADD rd=7 registered, then wb_stall=1 for 3 cycles with new inputs -> outputs hold rd=7/data; wb_instret unchanged. Then wb_flush=1 together with wb_stall=1 -> wb_valid=0, mem_wb_regwrite=0.
- Preload wb_instret to 2^64-1 via forced state, then retire one valid instruction -> wb_instret=0.
- reset=1 asserted in the same cycle as a valid load -> all outputs 0 next cycle. After reset deasserts, a bubble input (ex_mem_valid=0) leaves wb_instret=0.
